bcrypt_outpkt_builder: RTL and testbench

// - Downstream of the bcrypt arbiter: drains its one-entry output (type, pkt_id,
//   16x16 result memory, num_processed, hash_num) and serialises it into a framed
//   16-bit word stream for the output FIFO (host readout).
// - Frame: header, pkt_id, body length, body, checksum.
// - Pulses arb_rd_en once per frame, after the last word is written.

---
 rtl/bcrypt_outpkt_builder.sv | 168 ++++++++++++++++
 tb/tb_bcrypt_outpkt_builder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcrypt_outpkt_builder.sv
// Drains the bcrypt arbiter's one-entry output and serialises it as a framed
// 16-bit word stream: header, pkt_id, length, body, inverted-sum checksum.
module bcrypt_outpkt_builder #(
  parameter logic [3:0] VERSION      = 4'd2,
  parameter int         HASH_NUM_MSB = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  arb_empty,
  input  logic [1:0]            arb_type,
  output logic [3:0]            arb_rd_addr,
  input  logic [15:0]           arb_dout,
  input  logic [15:0]           arb_pkt_id,
  input  logic [31:0]           arb_num_proc,
  input  logic [HASH_NUM_MSB:0] arb_hash_num,
  output logic                  arb_rd_en,
  output logic [15:0]           out_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [15:0]           frame_count,
  output logic                  err
);

  localparam logic [1:0] T_RESULT  = 2'd0;
  localparam logic [1:0] T_CMP     = 2'd1;
  localparam logic [1:0] T_DONE    = 2'd2;
  localparam logic [1:0] T_INVALID = 2'd3;

  typedef enum logic [2:0] {IDLE, HDR, PKTID, LEN, BODY, CSUM, ACK, GAP} state_t;

  state_t                state;
  logic [1:0]            type_q;
  logic [15:0]           pkt_id_q;
  logic [31:0]           num_proc_q;
  logic [HASH_NUM_MSB:0] hash_q;
  logic [3:0]            idx;
  logic [15:0]           csum;
  logic                  wr_due;
  logic [15:0]           word;

  function automatic logic [15:0] body_len(input logic [1:0] t);
    case (t)
      T_RESULT: body_len = 16'd16;
      T_CMP:    body_len = 16'd4;
      T_DONE:   body_len = 16'd2;
      default:  body_len = 16'd0;
    endcase
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] t);
    case (t)
      T_RESULT: last_idx = 4'd15;
      T_CMP:    last_idx = 4'd3;
      default:  last_idx = 4'd1;
    endcase
  endfunction

  // CMP_RESULT body skips mem[1]: words come from mem[0], mem[2], mem[3].
  function automatic logic [3:0] body_addr(input logic [1:0] t, input logic [3:0] i);
    if (t == T_CMP) begin
      case (i)
        4'd1:    body_addr = 4'd2;
        4'd2:    body_addr = 4'd3;
        default: body_addr = 4'd0;
      endcase
    end else if (t == T_RESULT) begin
      body_addr = i;
    end else begin
      body_addr = 4'd0;
    end
  endfunction

  function automatic logic [15:0] body_word(input logic [1:0] t, input logic [3:0] i,
                                            input logic [15:0] mem_word);
    case (t)
      T_CMP:   body_word = (i == 4'd3) ? {{(15 - HASH_NUM_MSB){1'b0}}, hash_q} : mem_word;
      T_DONE:  body_word = (i == 4'd0) ? num_proc_q[15:0] : num_proc_q[31:16];
      default: body_word = mem_word;
    endcase
  endfunction

  always_comb begin
    wr_due = 1'b0;
    word   = 16'h0000;
    case (state)
      HDR:     begin wr_due = 1'b1; word = {VERSION, 2'b00, type_q, 8'h00}; end
      PKTID:   begin wr_due = 1'b1; word = pkt_id_q; end
      LEN:     begin wr_due = 1'b1; word = body_len(type_q); end
      BODY:    begin wr_due = 1'b1; word = body_word(type_q, idx, arb_dout); end
      CSUM:    begin wr_due = 1'b1; word = ~csum; end
      default: begin wr_due = 1'b0; word = 16'h0000; end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      arb_rd_addr <= 4'd0;
      arb_rd_en   <= 1'b0;
      out_dout    <= 16'h0000;
      out_wr_en   <= 1'b0;
      frame_count <= 16'h0000;
      err         <= 1'b0;
      csum        <= 16'h0000;
      idx         <= 4'd0;
      type_q      <= 2'd0;
      pkt_id_q    <= 16'h0000;
      num_proc_q  <= 32'h0;
      hash_q      <= '0;
    end else begin
      out_wr_en <= 1'b0;
      arb_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (!arb_empty) begin
            type_q     <= arb_type;
            pkt_id_q   <= arb_pkt_id;
            num_proc_q <= arb_num_proc;
            hash_q     <= arb_hash_num;
            csum       <= 16'h0000;
            idx        <= 4'd0;
            if (arb_type == T_INVALID) begin
              err   <= 1'b1;
              state <= ACK;
            end else begin
              state <= HDR;
            end
          end
        end
        ACK: begin
          arb_rd_en <= 1'b1;
          if (type_q != T_INVALID) frame_count <= frame_count + 16'd1;
          state <= GAP;
        end
        // Arbiter updates arb_empty one cycle after rd_en; skip that stale cycle.
        GAP: state <= IDLE;
        default: begin
          if (wr_due && !out_full) begin
            out_dout  <= word;
            out_wr_en <= 1'b1;
            csum      <= csum + word;
            case (state)
              HDR:   state <= PKTID;
              PKTID: begin
                state       <= LEN;
                arb_rd_addr <= body_addr(type_q, 4'd0);
              end
              LEN:   begin
                state <= BODY;
                idx   <= 4'd0;
              end
              BODY:  begin
                if (idx == last_idx(type_q)) begin
                  state <= CSUM;
                end else begin
                  idx         <= idx + 4'd1;
                  arb_rd_addr <= body_addr(type_q, idx + 4'd1);
                end
              end
              default: state <= ACK;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcrypt_outpkt_builder.sv
// Directed bench for bcrypt_outpkt_builder: a simple arbiter model feeds packets
// and every frame captured from the output strobe is compared to a frame model.
module tb_bcrypt_outpkt_builder;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        arb_empty = 1'b1;
  logic [1:0]  arb_type = 2'd0;
  logic [3:0]  arb_rd_addr;
  logic [15:0] arb_dout;
  logic [15:0] arb_pkt_id = 16'h0;
  logic [31:0] arb_num_proc = 32'h0;
  logic [3:0]  arb_hash_num = 4'h0;
  logic        arb_rd_en;
  logic [15:0] out_dout;
  logic        out_wr_en;
  logic        out_full = 1'b0;
  logic [15:0] frame_count;
  logic        err;

  logic [15:0] mem [16];
  logic [15:0] cap [$];
  logic [15:0] exp_q [$];
  int          rd_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  assign arb_dout = mem[arb_rd_addr];

  bcrypt_outpkt_builder #(.VERSION(4'd2), .HASH_NUM_MSB(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .arb_empty(arb_empty), .arb_type(arb_type),
    .arb_rd_addr(arb_rd_addr), .arb_dout(arb_dout), .arb_pkt_id(arb_pkt_id),
    .arb_num_proc(arb_num_proc), .arb_hash_num(arb_hash_num), .arb_rd_en(arb_rd_en),
    .out_dout(out_dout), .out_wr_en(out_wr_en), .out_full(out_full),
    .frame_count(frame_count), .err(err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (out_wr_en) cap.push_back(out_dout);
    if (arb_rd_en) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Appends the expected frame for the packet currently on the arbiter ports.
  task automatic add_exp(input logic [1:0] t);
    logic [15:0] w [$];
    logic [15:0] s;
    w.push_back({4'd2, 2'b00, t, 8'h00});
    w.push_back(arb_pkt_id);
    if (t == 2'd0) begin
      w.push_back(16'd16);
      for (int i = 0; i < 16; i++) w.push_back(mem[i]);
    end else if (t == 2'd1) begin
      w.push_back(16'd4);
      w.push_back(mem[0]); w.push_back(mem[2]); w.push_back(mem[3]);
      w.push_back({12'h000, arb_hash_num});
    end else begin
      w.push_back(16'd2);
      w.push_back(arb_num_proc[15:0]); w.push_back(arb_num_proc[31:16]);
    end
    s = 16'h0;
    foreach (w[i]) s = s + w[i];
    w.push_back(~s);
    foreach (w[i]) exp_q.push_back(w[i]);
  endtask

  task automatic load(input logic [1:0] t, input logic [15:0] id,
                      input logic [31:0] np, input logic [3:0] h);
    arb_type = t; arb_pkt_id = id; arb_num_proc = np; arb_hash_num = h;
    arb_empty = 1'b0;
  endtask

  // Waits for one rd_en pulse; the arbiter then empties unless keep is set.
  task automatic wait_rd(input string tag, input bit keep);
    int start = rd_cnt;
    int n = 0;
    while (rd_cnt == start && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_rd_timeout"}, (rd_cnt > start), 1);
    if (!keep) arb_empty = 1'b1;
  endtask

  task automatic cmp_frame(input string tag);
    chk({tag, "_nwords"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), cap[i], exp_q[i]);
    cap.delete();
    exp_q.delete();
  endtask

  initial begin
    int rd0;
    int n;
    logic [15:0] fc0;
    for (int i = 0; i < 16; i++) mem[i] = 16'(i * 16'h0101);
    repeat (3) tick();
    chk("rst_wr_en", out_wr_en, 0);
    chk("rst_rd_en", arb_rd_en, 0);
    chk("rst_dout", out_dout, 0);
    chk("rst_fcnt", frame_count, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", arb_rd_addr, 0);
    RST_N = 1'b1;
    tick();

    // PACKET_DONE golden frame
    load(2'd2, 16'h1234, 32'h0001_0005, 4'h0);
    exp_q = '{16'h2200, 16'h1234, 16'h0002, 16'h0005, 16'h0001, 16'hCBC3};
    rd0 = rd_cnt;
    wait_rd("pd", 1'b0);
    repeat (3) tick();
    cmp_frame("pd");
    chk("pd_rdcnt", rd_cnt - rd0, 1);
    chk("pd_fcnt", frame_count, 1);

    // RESULT, 16-word body
    load(2'd0, 16'hA5C3, 32'h0, 4'h0);
    add_exp(2'd0);
    chk("res_hdr_model", exp_q[0], 16'h2000);
    rd0 = rd_cnt;
    wait_rd("res", 1'b0);
    repeat (3) tick();
    cmp_frame("res");
    chk("res_rdcnt", rd_cnt - rd0, 1);
    chk("res_fcnt", frame_count, 2);

    // CMP_RESULT with a 3-cycle stall around body word 2
    load(2'd1, 16'hBEEF, 32'h0, 4'h3);
    add_exp(2'd1);
    n = 0;
    while (cap.size() < 4 && n < 100) begin tick(); n++; end
    chk("cmp_reach_body", (cap.size() >= 4), 1);
    out_full = 1'b1;
    tick(); tick();
    chk("cmp_stall_wr", out_wr_en, 0);
    tick();
    out_full = 1'b0;
    wait_rd("cmp", 1'b0);
    repeat (3) tick();
    cmp_frame("cmp");
    chk("cmp_fcnt", frame_count, 3);

    // Invalid type: no words, one read, sticky err
    load(2'd3, 16'h0BAD, 32'h0, 4'h0);
    rd0 = rd_cnt;
    wait_rd("inv", 1'b0);
    arb_type = 2'd0;
    repeat (3) tick();
    chk("inv_nwords", cap.size(), 0);
    chk("inv_rdcnt", rd_cnt - rd0, 1);
    chk("inv_err", err, 1);
    chk("inv_fcnt", frame_count, 3);
    cap.delete();

    // Reset during RESULT body word 5, then full re-emission
    load(2'd0, 16'h7777, 32'h0, 4'h0);
    n = 0;
    while (cap.size() < 8 && n < 100) begin tick(); n++; end
    chk("rst_reach_body5", cap.size(), 8);
    RST_N = 1'b0;
    #1;
    chk("midrst_wr_en", out_wr_en, 0);
    chk("midrst_rd_en", arb_rd_en, 0);
    chk("midrst_err", err, 0);
    chk("midrst_fcnt", frame_count, 0);
    tick(); tick();
    cap.delete();
    rd0 = rd_cnt;
    RST_N = 1'b1;
    add_exp(2'd0);
    wait_rd("rerun", 1'b0);
    repeat (3) tick();
    cmp_frame("rerun");
    chk("rerun_rdcnt", rd_cnt - rd0, 1);
    chk("rerun_fcnt", frame_count, 1);

    // Back-to-back packets
    fc0 = frame_count;
    rd0 = rd_cnt;
    load(2'd2, 16'h0A0A, 32'hDEAD_BEEF, 4'h0);
    add_exp(2'd2);
    wait_rd("b2b_a", 1'b1);
    load(2'd1, 16'h0B0B, 32'h0, 4'h9);
    add_exp(2'd1);
    wait_rd("b2b_b", 1'b0);
    repeat (6) tick();
    cmp_frame("b2b");
    chk("b2b_rdcnt", rd_cnt - rd0, 2);
    chk("b2b_fcnt", frame_count - fc0, 2);
    chk("b2b_idle_wr", out_wr_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
